// File: rtl/alu_in_pkg_hdl.sv
// Shared types for the alu_in responder: opcode and FSM state encodings.
package alu_in_pkg_hdl;

   typedef enum logic [2:0] {
      no_op  = 3'd0,
      add_op = 3'd1,
      and_op = 3'd2,
      xor_op = 3'd3,
      mul_op = 3'd4
   } alu_in_op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EXEC = 1'b1
   } alu_in_resp_state_t;

   // Reserved opcodes 5-7 behave like no_op: they occupy the FSM but never pulse done.
   function automatic logic is_result_op(input logic [2:0] o);
      return (o == add_op) || (o == and_op) || (o == xor_op) || (o == mul_op);
   endfunction

endpackage

// File: rtl/alu_in_resp_fifo.sv
// Synchronous FIFO for queued {op,a,b} requests; pointers wrap modulo DEPTH (power of 2).
module alu_in_resp_fifo #(
   parameter int DATA_W = 19,
   parameter int DEPTH  = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              push_ok, pop_ok;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

endmodule

// File: rtl/alu_in_responder.sv
// Responder end of the alu_in bus: queues ops, executes add/and/xor/mul, pulses done.
// Optional ALU_IN_RESP_STATS_EN adds saturating accept/overrun counters.
import alu_in_pkg_hdl::*;

module alu_in_responder #(
   parameter int ALU_IN_OP_WIDTH = 8,
   parameter int FIFO_DEPTH      = 2,
   parameter int MUL_LATENCY     = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         alu_rst,
   input  logic                         valid,
   input  alu_in_op_t                   op,
   input  logic [ALU_IN_OP_WIDTH-1:0]   a,
   input  logic [ALU_IN_OP_WIDTH-1:0]   b,
   output logic                         ready,
   output logic                         done,
`ifdef ALU_IN_RESP_STATS_EN
   output logic [15:0]                  stat_accept_cnt,
   output logic [15:0]                  stat_overrun_cnt,
`endif
   output logic [2*ALU_IN_OP_WIDTH-1:0] result
);

   localparam int W     = ALU_IN_OP_WIDTH;
   localparam int DW    = 3 + 2*W;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int LAT_W = $clog2(MUL_LATENCY + 1);

   logic               clr, push, pop;
   logic               fifo_full, fifo_empty;
   logic [DW-1:0]      fifo_rdata;
   logic [CNT_W-1:0]   fifo_count, fifo_count_next;

   alu_in_resp_state_t state, state_next;
   logic [LAT_W-1:0]   cnt, cnt_next;
   logic [2:0]         op_q, op_next;
   logic [W-1:0]       a_q, b_q, a_next, b_next;
   logic               done_next;
   logic [2*W-1:0]     result_next;

   // Either reset source flushes the queue and in-flight op; stats only follow rst.
   assign clr  = rst | alu_rst;
   assign push = valid & ready & ~fifo_full & ~clr;
   assign pop  = (state == S_IDLE) & ~fifo_empty & ~clr;
   assign fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

   alu_in_resp_fifo #(.DATA_W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .wdata ({op, a, b}),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   function automatic logic [2*W-1:0] alu_calc(input logic [2:0] o,
                                               input logic [W-1:0] x, y);
      case (o)
         add_op:  return {{(W-1){1'b0}}, {1'b0, x} + {1'b0, y}};
         and_op:  return {{W{1'b0}}, x & y};
         xor_op:  return {{W{1'b0}}, x ^ y};
         mul_op:  return (2*W)'(x) * (2*W)'(y);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      op_next     = op_q;
      a_next      = a_q;
      b_next      = b_q;
      done_next   = 1'b0;
      result_next = result;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               op_next    = fifo_rdata[DW-1 -: 3];
               a_next     = fifo_rdata[2*W-1 -: W];
               b_next     = fifo_rdata[W-1:0];
               cnt_next   = (op_next == mul_op) ? LAT_W'(MUL_LATENCY) : LAT_W'(1);
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (cnt == LAT_W'(1)) begin
               state_next = S_IDLE;
               if (is_result_op(op_q)) begin
                  done_next   = 1'b1;
                  result_next = alu_calc(op_q, a_q, b_q);
               end
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= S_IDLE;
         cnt    <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         done   <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         op_q   <= op_next;
         a_q    <= a_next;
         b_q    <= b_next;
         done   <= done_next;
         result <= result_next;
         ready  <= (fifo_count_next < CNT_W'(FIFO_DEPTH));
      end
   end

`ifdef ALU_IN_RESP_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_accept_cnt  <= '0;
         stat_overrun_cnt <= '0;
      end else begin
         if (push && stat_accept_cnt != 16'hFFFF)
            stat_accept_cnt <= stat_accept_cnt + 16'd1;
         if (valid && !ready && stat_overrun_cnt != 16'hFFFF)
            stat_overrun_cnt <= stat_overrun_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_in_responder.sv
// Self-checking bench for alu_in_responder: directed cases plus random traffic vs a queue model.
module tb_alu_in_responder;
   import alu_in_pkg_hdl::*;

   localparam int W     = 8;
   localparam int DEPTH = 2;
   localparam int ML    = 3;

   logic           clk = 1'b0;
   logic           rst, alu_rst, valid;
   alu_in_op_t     op;
   logic [W-1:0]   a, b;
   logic           ready, done;
   logic [2*W-1:0] result;
`ifdef ALU_IN_RESP_STATS_EN
   logic [15:0]    stat_accept_cnt, stat_overrun_cnt;
`endif

   alu_in_responder #(.ALU_IN_OP_WIDTH(W), .FIFO_DEPTH(DEPTH), .MUL_LATENCY(ML)) dut (
      .clk     (clk),
      .rst     (rst),
      .alu_rst (alu_rst),
      .valid   (valid),
      .op      (op),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .done    (done),
`ifdef ALU_IN_RESP_STATS_EN
      .stat_accept_cnt  (stat_accept_cnt),
      .stat_overrun_cnt (stat_overrun_cnt),
`endif
      .result  (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned op;
      int unsigned x;
      int unsigned y;
   } txn_t;

   txn_t           q[$];
   txn_t           cur;
   int             rem;
   logic           ready_m, done_m;
   logic [2*W-1:0] result_m;
   int             acc_m, ovr_m;
   int             n_chk, n_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_calc(input txn_t t);
      case (t.op)
         1:       return (2*W)'(t.x + t.y);
         2:       return (2*W)'(t.x & t.y);
         3:       return (2*W)'(t.x ^ t.y);
         4:       return (2*W)'(t.x * t.y);
         default: return '0;
      endcase
   endfunction

   // Advance model and DUT by one edge, then compare every observable output.
   task automatic tick();
      txn_t t;
      bit   acc;
      acc = valid && ready_m && !rst && !alu_rst;
      if (rst) begin
         acc_m = 0;
         ovr_m = 0;
      end else begin
         if (acc && acc_m < 65535) acc_m++;
         if (valid && !ready_m && ovr_m < 65535) ovr_m++;
      end
      if (rst || alu_rst) begin
         q.delete();
         rem      = 0;
         ready_m  = 1'b0;
         done_m   = 1'b0;
         result_m = '0;
      end else begin
         done_m = 1'b0;
         if (rem > 0) begin
            rem--;
            if (rem == 0 && cur.op >= 1 && cur.op <= 4) begin
               done_m   = 1'b1;
               result_m = ref_calc(cur);
            end
         end else if (q.size() > 0) begin
            cur = q.pop_front();
            rem = (cur.op == 4) ? ML : 1;
         end
         if (acc) begin
            t.op = 32'(op);
            t.x  = 32'(a);
            t.y  = 32'(b);
            q.push_back(t);
         end
         ready_m = (q.size() < DEPTH);
      end
      @(posedge clk);
      #1;
      chk("ready", 32'(ready), 32'(ready_m));
      chk("done", 32'(done), 32'(done_m));
      chk("result", 32'(result), 32'(result_m));
`ifdef ALU_IN_RESP_STATS_EN
      chk("stat_accept", 32'(stat_accept_cnt), 32'(acc_m));
      chk("stat_overrun", 32'(stat_overrun_cnt), 32'(ovr_m));
`endif
   endtask

   task automatic send(input alu_in_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
      valid = 1'b1;
      op    = o;
      a     = x;
      b     = y;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rem = 0; ready_m = 1'b0; done_m = 1'b0; result_m = '0; acc_m = 0; ovr_m = 0;
      rst = 1'b1; alu_rst = 1'b0; valid = 1'b0; op = no_op; a = '0; b = '0;
      @(negedge clk);
      tick(); tick();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", 32'(ready), 32'd1);

      // add FF+01: done two edges after accept
      send(add_op, 8'hFF, 8'h01); tick(); valid = 1'b0;
      tick(); chk("add_early_done", 32'(done), 32'd0);
      tick(); chk("add_done", 32'(done), 32'd1); chk("add_result", 32'(result), 32'h0100);
      tick();

      // mul FF*FF: done 1+MUL_LATENCY edges after accept
      send(mul_op, 8'hFF, 8'hFF); tick(); valid = 1'b0;
      tick(); tick(); tick(); chk("mul_early_done", 32'(done), 32'd0);
      tick(); chk("mul_done", 32'(done), 32'd1); chk("mul_result", 32'(result), 32'hFE01);
      tick();

      // back-to-back xor/and/add fills the 2-deep queue
      send(xor_op, 8'h0F, 8'hF0); tick();
      send(and_op, 8'hAA, 8'h0F); tick();
      send(add_op, 8'h80, 8'h80); tick();
      chk("full_ready", 32'(ready), 32'd0);
      valid = 1'b0;
      repeat (8) tick();
      chk("b2b_last_result", 32'(result), 32'h0100);

      // reserved then no_op: no done, result held
      send(alu_in_op_t'(3'b110), 8'h12, 8'h34); tick();
      send(no_op, 8'h56, 8'h78); tick();
      valid = 1'b0;
      repeat (6) tick();
      chk("rsv_result", 32'(result), 32'h0100);
      send(add_op, 8'h01, 8'h02); tick(); valid = 1'b0;
      tick(); tick(); chk("post_rsv_add", 32'(result), 32'h0003);
      tick();

      // alu_rst during mul EXEC with one op queued
      send(mul_op, 8'h10, 8'h10); tick();
      send(add_op, 8'h05, 8'h05); tick();
      valid = 1'b0;
      alu_rst = 1'b1; tick(); alu_rst = 1'b0;
      chk("arst_ready", 32'(ready), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      tick(); chk("arst_ready_back", 32'(ready), 32'd1);
      repeat (6) tick();

      // hold valid while the queue is full to exercise overrun
      for (int i = 0; i < 10; i++) begin
         send(mul_op, 8'(i), 8'(i + 1));
         tick();
      end
      valid = 1'b0;
      repeat (10) tick();

      // random traffic
      for (int i = 0; i < 500; i++) begin
         valid   = ($urandom_range(0, 99) < 65);
         op      = alu_in_op_t'(3'($urandom_range(0, 7)));
         a       = 8'($urandom);
         b       = 8'($urandom);
         alu_rst = ($urandom_range(0, 59) == 0);
         rst     = ($urandom_range(0, 249) == 0);
         tick();
      end
      valid = 1'b0; alu_rst = 1'b0; rst = 1'b0;
      repeat (10) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
